// File: rtl/tile_row_fetch.sv
// tile_row_fetch: fetch one glyph row from the tile BRAM and stream it MSB-first as 1bpp pixels
module tile_row_fetch #(
    parameter int AWIDTH = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [AWIDTH-1:0] req_base_i,
    input  logic [7:0]        req_tile_i,
    input  logic [3:0]        req_row_i,
    input  logic              req_h16_i,
    output logic [AWIDTH-1:0] tile_addr_o,
    input  logic [15:0]       tile_data_i,
    output logic              pix_valid_o,
    input  logic              pix_ready_i,
    output logic              pix_o,
    output logic              pix_last_o,
    output logic              busy_o
);
    typedef enum logic [1:0] {IDLE, ADDR, WAIT, SHIFT} state_t;
    state_t            state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic              bsel_q, bsel_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [AWIDTH-1:0] addr_calc;
    logic              row_done;
    logic              accept;

    // Each word packs two rows, so the word offset is row/2 and row[0] picks the byte.
    // Summing at AWIDTH width gives the same result as full precision truncated afterwards.
    assign addr_calc = req_h16_i
        ? req_base_i + AWIDTH'({req_tile_i, 3'b000}) + AWIDTH'(req_row_i[3:1])
        : req_base_i + AWIDTH'({req_tile_i, 2'b00}) + AWIDTH'(req_row_i[2:1]);

    // The last pixel handshake frees the block, letting the next request chain without an IDLE cycle.
    assign row_done    = (state_q == SHIFT) && (cnt_q == 3'd7) && pix_ready_i;
    assign req_ready_o = (state_q == IDLE) || row_done;
    assign accept      = req_valid_i && req_ready_o;

    assign tile_addr_o = addr_q;
    assign pix_valid_o = (state_q == SHIFT);
    assign pix_o       = pix_valid_o && shreg_q[7];
    assign pix_last_o  = pix_valid_o && (cnt_q == 3'd7);
    assign busy_o      = (state_q != IDLE);

    // Next-state and datapath update: latch address on accept, load row in WAIT, shift on handshake
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        bsel_d  = bsel_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (accept) begin
            addr_d = addr_calc;
            bsel_d = req_row_i[0];
        end
        case (state_q)
            IDLE:  state_d = accept ? ADDR : IDLE;
            ADDR:  state_d = WAIT;
            WAIT: begin
                shreg_d = bsel_q ? tile_data_i[7:0] : tile_data_i[15:8];
                cnt_d   = 3'd0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (pix_ready_i) begin
                    shreg_d = {shreg_q[6:0], 1'b0};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_d = accept ? ADDR : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            bsel_q  <= 1'b0;
            shreg_q <= 8'd0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            bsel_q  <= bsel_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_tile_row_fetch.sv
// tb_tile_row_fetch: directed requests with a pixel scoreboard checked by an independent monitor
module tb_tile_row_fetch;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [11:0] req_base = '0;
    logic [7:0]  req_tile = '0;
    logic [3:0]  req_row = '0;
    logic        req_h16 = 1'b0;
    logic [11:0] tile_addr;
    logic [15:0] tile_data = '0;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        pix;
    logic        pix_last;
    logic        busy;
    logic [15:0] mem [4096];
    logic [1:0]  sb [$];
    int          vecs = 0;
    int          fails = 0;
    int          hs = 0;
    logic        lst;
    int          s;

    tile_row_fetch #(.AWIDTH(12)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_base_i(req_base), .req_tile_i(req_tile), .req_row_i(req_row), .req_h16_i(req_h16),
        .tile_addr_o(tile_addr), .tile_data_i(tile_data),
        .pix_valid_o(pix_valid), .pix_ready_i(pix_ready), .pix_o(pix), .pix_last_o(pix_last),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    // BRAM model with one-cycle registered read
    always @(posedge clk) tile_data <= mem[tile_addr];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Pop one expected {pixel,last} per pixel handshake
    always @(negedge clk) begin
        logic [1:0] e;
        if (!reset && pix_valid && pix_ready) begin
            hs++;
            if (sb.size() == 0) begin
                vecs++;
                fails++;
                $display("FAIL pixel: got %b%b expected nothing (queue empty)", pix, pix_last);
            end else begin
                e = sb.pop_front();
                chk("pixel", {14'd0, pix, pix_last}, {14'd0, e});
            end
        end
    end

    task automatic issue(input logic [11:0] b, input logic [7:0] t, input logic [3:0] r,
                         input logic h, input logic [11:0] ea, input logic [7:0] eb,
                         output logic last_at_accept);
        bit ok = 0;
        for (int i = 0; i < 8; i++) sb.push_back({eb[7-i], 1'(i == 7)});
        req_base = b; req_tile = t; req_row = r; req_h16 = h; req_valid = 1'b1;
        last_at_accept = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                last_at_accept = pix_last;
                break;
            end
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (!ok) begin
            vecs++;
            fails++;
            $display("FAIL accept_timeout: got no req_ready expected accept");
        end
        chk("tile_addr", {4'd0, tile_addr}, {4'd0, ea});
    endtask

    task automatic gap_chk(input string nm);
        chk(nm, {15'd0, pix_valid}, 16'd0);
        @(posedge clk); #1 chk(nm, {15'd0, pix_valid}, 16'd0);
        @(posedge clk); #1 chk(nm, {15'd0, pix_valid}, 16'd1);
    endtask

    task automatic drain();
        bit ok = 0;
        for (int n = 0; n < 300; n++) begin
            if (sb.size() == 0 && !busy) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            vecs++;
            fails++;
            $display("FAIL drain: got %0d pixels pending expected 0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[12'h20A] = 16'hA53C;
        mem[12'h905] = 16'hF00F;
        mem[12'h6FF] = 16'h12C3;
        mem[12'h110] = 16'h5A00;
        mem[12'h005] = 16'h0081;
        mem[12'h012] = 16'hE700;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_valid", {15'd0, pix_valid}, 16'd0);
        chk("rst_pix", {15'd0, pix}, 16'd0);
        chk("rst_last", {15'd0, pix_last}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_ready", {15'd0, req_ready}, 16'd1);
        chk("rst_addr", {4'd0, tile_addr}, 16'd0);

        issue(12'h000, 8'h41, 4'd5, 1'b1, 12'h20A, 8'h3C, lst);
        chk("idle_last_at_accept", {15'd0, lst}, 16'd0);
        gap_chk("latency");
        drain();
        issue(12'h800, 8'h41, 4'd2, 1'b0, 12'h905, 8'hF0, lst);
        drain();
        issue(12'h800, 8'h41, 4'd10, 1'b0, 12'h905, 8'hF0, lst);
        drain();
        issue(12'hF00, 8'hFF, 4'd15, 1'b1, 12'h6FF, 8'hC3, lst);
        drain();

        issue(12'h100, 8'h02, 4'd0, 1'b1, 12'h110, 8'h5A, lst);
        s = hs;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (hs - s >= 3) break;
        end
        pix_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", {15'd0, pix_valid}, 16'd1);
            chk("bp_pix", {15'd0, pix}, 16'd1);
            chk("bp_last", {15'd0, pix_last}, 16'd0);
        end
        @(posedge clk);
        #1 pix_ready = 1'b1;
        drain();
        chk("bp_handshakes", 16'(hs - s), 16'd8);

        issue(12'h000, 8'h01, 4'd3, 1'b0, 12'h005, 8'h81, lst);
        issue(12'h000, 8'h02, 4'd4, 1'b1, 12'h012, 8'hE7, lst);
        chk("b2b_last_at_accept", {15'd0, lst}, 16'd1);
        gap_chk("b2b_gap");
        drain();

        issue(12'h000, 8'h41, 4'd5, 1'b1, 12'h20A, 8'h3C, lst);
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            if (pix_valid) break;
        end
        @(posedge clk);
        #2 reset = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_valid", {15'd0, pix_valid}, 16'd0);
        chk("mid_rst_busy", {15'd0, busy}, 16'd0);
        chk("mid_rst_ready", {15'd0, req_ready}, 16'd1);
        chk("mid_rst_addr", {4'd0, tile_addr}, 16'd0);
        #1 reset = 1'b0;
        issue(12'h000, 8'h41, 4'd4, 1'b1, 12'h20A, 8'hA5, lst);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule

// File: doc/tile_row_fetch.md
Name: tile_row_fetch

Overview:
Read-side client of the tile/font BRAM. It accepts a glyph-row request (font base, tile index, row, 8x16 or 8x8 cell) and drives the BRAM read address. It captures the 16-bit word after the BRAM's one-cycle registered read latency and selects the 8-bit row. It then serializes that row MSB-first as 1bpp pixels under a valid/ready handshake for the text-mode pixel path.

Parameters:
AWIDTH, 12, tile memory word-address width; all address arithmetic wraps modulo 2**AWIDTH

Ports:
clk  in  1  single clock, shared with tile BRAM read port
reset  in  1  asynchronous, active-high reset
req_valid_i  in  1  row request present; requester holds all req_* stable until accepted
req_ready_o  out  1  request accepted on a clk edge where req_valid_i && req_ready_o
req_base_i  in  AWIDTH  font base word address
req_tile_i  in  8  tile/character index
req_row_i  in  4  pixel row within cell (8x8 mode ignores bit 3)
req_h16_i  in  1  1 = 8x16 cell, 0 = 8x8 cell
tile_addr_o  out  AWIDTH  BRAM read address (registered)
tile_data_i  in  16  BRAM read data, valid one clk after tile_addr_o is sampled
pix_valid_o  out  1  pix_o is valid
pix_ready_i  in  1  consumer takes pix_o this cycle
pix_o  out  1  current pixel (1 = foreground)
pix_last_o  out  1  pix_o is pixel 7 of the row
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE; tile_addr_o=0, shift reg=0, count=0, byte-select=0. Outputs after reset: pix_valid_o=0, pix_o=0, pix_last_o=0, busy_o=0, req_ready_o=1.
- Word layout: one word holds two rows. bits[15:8] = even row, bits[7:0] = odd row.
- Address on accept, computed at full precision and then truncated to AWIDTH (wraps):
  - h16=1: base + tile*8 + row[3:1]
  - h16=0: base + tile*4 + row[2:1]
  - Byte-select = row[0] is registered alongside the address.
- States:
  - IDLE: req_ready_o=1. On accept, register tile_addr_o and byte-select, then go to ADDR.
  - ADDR: address is presented to BRAM; BRAM samples it at the end of this cycle. Next state WAIT.
  - WAIT: tile_data_i is valid. Load the selected byte into the 8-bit shift reg, set count=0, go to SHIFT.
  - SHIFT:
    - pix_valid_o=1, pix_o=shreg[7], pix_last_o=(count==7).
    - On pix_ready_i: shift left (zero fill) and increment count.
    - On the handshake with count==7: go to IDLE, or go straight to ADDR if a request is accepted the same cycle.
- Latency: for a request accepted at edge N, tile_addr_o is valid after N; pix_valid_o is first high after edge N+2; the row completes at best after N+10.
- Back-to-back requests: req_ready_o = IDLE || (SHIFT && count==7 && pix_ready_i). This is a combinational path from pix_ready_i. Consecutive rows then stream with a 2-cycle pixel gap.
- Backpressure: with pix_ready_i=0, pix_o, pix_last_o, count and the shift reg hold indefinitely.
- req_valid_i while not ready: ignored. Not latched, no error.
- tile_addr_o holds its last value outside ADDR/WAIT.
- tile_data_i is sampled only in WAIT.
- BRAM write port collisions are outside this block: it uses whatever word the BRAM returns in WAIT.

Test Plan:
- 8x16 odd row: base=0x000, tile=0x41, row=5, h16=1 -> tile_addr_o=0x20A after the accept edge. BRAM returns 0xA53C -> pixels 0,0,1,1,1,1,0,0, with pix_last_o only on the 8th pixel.
- 8x8 even row: base=0x800, tile=0x41, row=2 (bit 3 set variant row=10 gives the same result), h16=0 -> tile_addr_o=0x905. Data 0xF00F -> pixels 1,1,1,1,0,0,0,0.
- Address wrap: base=0xF00, tile=0xFF, row=15, h16=1 -> tile_addr_o=0x6FF. Byte-select is the low byte.
- Backpressure: deassert pix_ready_i for 5 cycles at pixel 3 -> pix_o and pix_last_o stable, no pixel lost or duplicated; the row completes after all 8 handshakes.
- Back-to-back: req_valid_i held high with a second request -> accepted on the same edge as the pixel-7 handshake. The next tile_addr_o appears then, and pix_valid_o is low for exactly 2 cycles between rows.
- Reset mid-SHIFT (async, between edges) -> pix_valid_o=0 and busy_o=0 immediately, req_ready_o=1. The next request fetches correctly with no stale pixels.
